// File: rtl/wb_stage.sv
// wb_stage: write-back stage completing loads and driving the register file write port (optional WB_TRACE_EN adds trace outputs and retire counter)
module wb_stage #(
  parameter int MEM_TO_WB_WD = 76
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mem_to_wb_valid,
  input  logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic                    wb_allowin,
  input  logic                    flush,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic [37:0]             wb_to_id_bus
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata,
  output logic [31:0]             retire_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, DONE, WAIT, DISCARD} state_t;
  state_t state, nxt;
  logic        we_r;
  logic [4:0]  waddr_r;
  logic [2:0]  lt_r;
  logic [1:0]  lo_r;
  logic [31:0] wdata_r;
  logic        in_we, in_ld, accept, cap_wait, cap_acc;
  logic [4:0]  in_waddr;
  logic [2:0]  in_lt;
  logic [1:0]  in_lo;
  logic [31:0] in_res, aligned;
  assign in_we    = mem_to_wb_bus[43];
  assign in_waddr = mem_to_wb_bus[42:38];
  assign in_ld    = mem_to_wb_bus[37];
  assign in_lt    = mem_to_wb_bus[36:34];
  assign in_lo    = mem_to_wb_bus[33:32];
  assign in_res   = mem_to_wb_bus[31:0];
  assign wb_allowin = state == IDLE || state == DONE;
  assign accept     = mem_to_wb_valid && wb_allowin && !flush;
  assign cap_acc    = accept && (!in_ld || data_sram_data_ok);
  assign cap_wait   = state == WAIT && data_sram_data_ok && !flush;
  function automatic logic [31:0] align(input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lo, 3'b000} +: 8];
    h = lo[1] ? d[31:16] : d[15:0];
    return lt == 3'd1 ? {{24{b[7]}}, b} :
           lt == 3'd2 ? {24'd0, b} :
           lt == 3'd3 ? {{16{h[15]}}, h} :
           lt == 3'd4 ? {16'd0, h} : d;
  endfunction
  // align returned data using fields of the instruction being accepted or the one waiting
  always_comb begin
    aligned = accept ? align(in_lt, in_lo, data_sram_rdata) : align(lt_r, lo_r, data_sram_rdata);
  end
  // next state: load hold, flush discard, one-cycle DONE per instruction
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = accept ? ((in_ld && !data_sram_data_ok) ? WAIT : DONE) : IDLE;
      WAIT:       nxt = data_sram_data_ok ? (flush ? IDLE : DONE) : (flush ? DISCARD : WAIT);
      DISCARD:    nxt = data_sram_data_ok ? IDLE : DISCARD;
      default:    nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= nxt;
  end
  // field registers captured on transfer; write data captured from result or aligned load data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      we_r    <= 1'b0;
      waddr_r <= 5'd0;
      lt_r    <= 3'd0;
      lo_r    <= 2'd0;
      wdata_r <= 32'd0;
    end else begin
      if (accept) begin
        we_r    <= in_we;
        waddr_r <= in_waddr;
        lt_r    <= in_lt;
        lo_r    <= in_lo;
      end
      if (cap_acc) wdata_r <= in_ld ? aligned : in_res;
      else if (cap_wait) wdata_r <= aligned;
    end
  end
  assign rf_we        = state == DONE && we_r;
  assign rf_waddr     = waddr_r;
  assign rf_wdata     = wdata_r;
  assign wb_to_id_bus = {rf_we, rf_waddr, rf_wdata};
`ifdef WB_TRACE_EN
  logic [31:0] pc_r;
  // pc of the instruction in WB and count of completed instructions
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_r       <= 32'd0;
      retire_cnt <= 32'd0;
    end else begin
      if (accept) pc_r <= mem_to_wb_bus[75:44];
      if (state == DONE) retire_cnt <= retire_cnt + 32'd1;
    end
  end
  assign debug_wb_pc       = pc_r;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  logic unused_pc;
  assign unused_pc = ^mem_to_wb_bus[75:44];
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage with directed vectors
module tb_wb_stage;
  logic        clk = 0, resetn = 0, valid = 0, flush = 0, data_ok = 0;
  logic [75:0] bus = '0;
  logic [31:0] rdata = '0;
  logic        wb_allowin, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [37:0] wb_to_id_bus;
`ifdef WB_TRACE_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata, retire_cnt;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] c0;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [37:0] q[$];
  wb_stage dut (
    .clk(clk), .resetn(resetn), .mem_to_wb_valid(valid), .mem_to_wb_bus(bus),
    .wb_allowin(wb_allowin), .flush(flush), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .wb_to_id_bus(wb_to_id_bus)
`ifdef WB_TRACE_EN
    , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .retire_cnt(retire_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [75:0] mk(input logic we, input logic [4:0] wa, input logic ld,
                                     input logic [2:0] lt, input logic [1:0] lo, input logic [31:0] res);
    return {32'hBFC0_0000, we, wa, ld, lt, lo, res};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [75:0] b, input logic dok, input logic [31:0] rd);
    int t = 0;
    while (!wb_allowin && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (!wb_allowin) chk("allowin_timeout", 64'(wb_allowin), 64'd1);
    valid = 1; bus = b; data_ok = dok; rdata = rd;
    @(posedge clk); #1;
    valid = 0; data_ok = 0;
  endtask
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got %h expected no write", wb_to_id_bus);
      end else begin
        automatic logic [37:0] e = q.pop_front();
        if (wb_to_id_bus !== e) begin
          n_bad++;
          $display("FAIL write: got %h expected %h", wb_to_id_bus, e);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  localparam logic [31:0] RD = 32'h80FF_00AA;
  initial begin
    #2;
    chk("rst_allowin", 64'(wb_allowin), 64'd1);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_bus", 64'(wb_to_id_bus), 64'd0);
    chk("rst_waddr_wdata", {27'd0, rf_waddr, rf_wdata}, 64'd0);
    #10 resetn = 1;
    @(posedge clk); #1;
    q.push_back({1'b1, 5'd8, 32'h1234_5678});
    send(mk(1, 5'd8, 0, 3'd0, 2'd0, 32'h1234_5678), 0, 0);
    @(posedge clk); #1;
    q.push_back({1'b1, 5'd9, 32'hFFFF_FF80});
    send(mk(1, 5'd9, 1, 3'd1, 2'b11, 32'h0), 0, 0);
    chk("lb_wait0", 64'(wb_allowin), 64'd0);
    @(posedge clk); #1;
    chk("lb_wait1", 64'(wb_allowin), 64'd0);
    @(posedge clk); #1;
    chk("lb_wait2", 64'(wb_allowin), 64'd0);
    data_ok = 1; rdata = RD;
    @(posedge clk); #1;
    data_ok = 0;
    chk("lb_done_allowin", 64'(wb_allowin), 64'd1);
    @(posedge clk); #1;
    q.push_back({1'b1, 5'd10, 32'h0000_80FF});
    send(mk(1, 5'd10, 1, 3'd4, 2'b10, 32'h0), 1, RD);
    q.push_back({1'b1, 5'd11, 32'h80FF_00AA}); send(mk(1, 5'd11, 1, 3'd0, 2'b00, 0), 1, RD);
    q.push_back({1'b1, 5'd12, 32'hFFFF_FFAA}); send(mk(1, 5'd12, 1, 3'd1, 2'b00, 0), 1, RD);
    q.push_back({1'b1, 5'd13, 32'hFFFF_FFFF}); send(mk(1, 5'd13, 1, 3'd1, 2'b10, 0), 1, RD);
    q.push_back({1'b1, 5'd14, 32'h0000_0000}); send(mk(1, 5'd14, 1, 3'd2, 2'b01, 0), 1, RD);
    q.push_back({1'b1, 5'd15, 32'h0000_0080}); send(mk(1, 5'd15, 1, 3'd2, 2'b11, 0), 1, RD);
    q.push_back({1'b1, 5'd16, 32'h0000_00AA}); send(mk(1, 5'd16, 1, 3'd3, 2'b00, 0), 1, RD);
    q.push_back({1'b1, 5'd17, 32'hFFFF_80FF}); send(mk(1, 5'd17, 1, 3'd3, 2'b10, 0), 1, RD);
    q.push_back({1'b1, 5'd18, 32'h80FF_00AA}); send(mk(1, 5'd18, 1, 3'd6, 2'b01, 0), 1, RD);
    send(mk(0, 5'd19, 0, 3'd0, 2'd0, 32'hDEAD_BEEF), 0, 0);
    @(posedge clk); #1;
    send(mk(1, 5'd20, 1, 3'd0, 2'd0, 0), 0, 0);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("discard_allowin0", 64'(wb_allowin), 64'd0);
    @(posedge clk); #1;
    chk("discard_allowin1", 64'(wb_allowin), 64'd0);
    data_ok = 1; rdata = RD;
    @(posedge clk); #1;
    data_ok = 0;
    chk("discard_release", 64'(wb_allowin), 64'd1);
    @(posedge clk); #1;
`ifdef WB_TRACE_EN
    c0 = retire_cnt;
`endif
    q.push_back({1'b1, 5'd0, 32'h0000_0001});
    q.push_back({1'b1, 5'd31, 32'h0000_001F});
    valid = 1; bus = mk(1, 5'd0, 0, 3'd0, 2'd0, 32'h1);
    @(posedge clk); #1;
    bus = mk(1, 5'd31, 0, 3'd0, 2'd0, 32'h1F);
    @(posedge clk); #1;
    valid = 0;
    @(posedge clk); #1;
`ifdef WB_TRACE_EN
    chk("retire_cnt", 64'(retire_cnt), 64'(c0 + 32'd2));
`endif
    send(mk(1, 5'd21, 1, 3'd0, 2'd0, 0), 0, 0);
    @(posedge clk); #3;
    resetn = 0;
    #1;
    chk("mid_rst_allowin", 64'(wb_allowin), 64'd1);
    chk("mid_rst_bus", 64'(wb_to_id_bus), 64'd0);
    @(posedge clk); #3;
    resetn = 1;
    @(posedge clk); #1;
    data_ok = 1; rdata = RD;
    @(posedge clk); #1;
    data_ok = 0;
    chk("post_rst_allowin", 64'(wb_allowin), 64'd1);
    chk("post_rst_bus", 64'(wb_to_id_bus), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage pipeline: accepts the MEM-stage result bus, completes loads by aligning and extending the returned data-SRAM word, and drives the register file write port (`we`/`waddr`/`wdata`). It also publishes a 38-bit `wb_to_id_bus` in the same `{we, waddr[4:0], wdata[31:0]}` packing the register file already takes from EX, so ID can forward from WB. A small state machine holds a load until its data returns and discards data belonging to a flushed load.

## Interface
Parameters:
- `MEM_TO_WB_WD`, 76: width of `mem_to_wb_bus`.

Ports:
- `clk`  in  1  pipeline clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_to_wb_valid`  in  1  MEM holds a valid instruction.
- `mem_to_wb_bus`  in  76  `{pc[31:0], rf_we, rf_waddr[4:0], is_load, load_type[2:0], addr_lo[1:0], result[31:0]}`, MSB first.
- `wb_allowin`  out  1  WB accepts a new instruction this cycle.
- `flush`  in  1  exception/ERET flush from the CP0 path.
- `data_sram_data_ok`  in  1  load data valid this cycle.
- `data_sram_rdata`  in  32  load data word.
- `rf_we`  out  1  register file write enable.
- `rf_waddr`  out  5  register file write address.
- `rf_wdata`  out  32  register file write data.
- `wb_to_id_bus`  out  38  `{rf_we, rf_waddr, rf_wdata}`.

## Operation
- Handshake: an instruction transfers at a posedge where `mem_to_wb_valid && wb_allowin && !flush`; its fields are registered.
- States: IDLE (no instruction), DONE (non-load, or load with data captured), WAIT (load, data outstanding), DISCARD (flushed load, data still outstanding).
- IDLE/DONE -> WAIT on accepting a load without `data_ok` in the same cycle. They go -> DONE on accepting a non-load, or a load with `data_ok` high. They go -> IDLE with no transfer.
- WAIT -> DONE on `data_ok` (data registered). WAIT -> DISCARD on `flush` without `data_ok`. WAIT -> IDLE on `flush` with `data_ok`.
- DISCARD -> IDLE on `data_ok`. The data is dropped.
- `wb_allowin` = 1 in IDLE/DONE and 0 in WAIT/DISCARD.
- `rf_we` = 1 only in DONE with the registered `rf_we` field set. DONE lasts exactly one cycle per instruction. `waddr` of 0 is passed through; the register file ignores it.
- Load alignment: the byte is selected by `addr_lo` and the halfword by `addr_lo[1]`.
  - `load_type` 000 = LW.
  - 001 = LB, sign-extended.
  - 010 = LBU, zero-extended.
  - 011 = LH, sign-extended.
  - 100 = LHU, zero-extended.
  - 101–111 behave as LW.
- Non-load: `rf_wdata` = registered `result`.
- `flush` does not cancel an instruction already in DONE. It blocks the transfer in its own cycle.

## Timing
- Latency: a non-load accepted at edge N writes at edge N+1 (`rf_we` high during cycle N→N+1).
- A load whose `data_ok` arrives k cycles after acceptance (k≥1) has `rf_we` high in the cycle after the `data_ok` edge.
- `data_ok` that coincides with acceptance means k=0, and the load behaves like a non-load.
- `rf_*` and `wb_to_id_bus` are driven from registers only. There is no combinational path from `data_sram_rdata`.
- `wb_allowin` depends only on state (registered).
- Reset, asynchronous with `resetn`=0: state IDLE.
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `wb_to_id_bus`=0.
  - `wb_allowin`=1.
  - All field registers are 0.
- Reset in WAIT/DISCARD abandons the pending load. A stray `data_ok` after reset is ignored in IDLE.
- `data_ok` in IDLE/DONE without acceptance of a load is ignored.

## Configuration
- `WB_TRACE_EN` defined: adds outputs `debug_wb_pc[31:0]`, `debug_wb_rf_wen[3:0]`, `debug_wb_rf_wnum[4:0]`, `debug_wb_rf_wdata[31:0]` and `retire_cnt[31:0]`.
  - `debug_wb_pc` = registered pc.
  - `debug_wb_rf_wen` = {4{rf_we}}.
  - `debug_wb_rf_wnum` = `rf_waddr`; `debug_wb_rf_wdata` = `rf_wdata`.
  - `retire_cnt` increments on every DONE cycle (including `rf_we`=0), wraps at 2^32, and resets to 0.
- Not defined: these ports and the counter do not exist. Functional behaviour is identical.

## Test plan
- ADDU, rf_we=1, waddr=5'd8, result=32'h1234_5678, accepted at edge 1 -> `rf_we`=1, `wb_to_id_bus`={1,8,32'h12345678} in cycle 1→2, then `rf_we`=0.
- LB at addr_lo=2'b11, rdata=32'h80FF_00AA, `data_ok` 3 cycles later -> `wb_allowin`=0 for 3 cycles, then write 32'hFFFF_FF80.
- LHU at addr_lo=2'b10 with the same rdata and `data_ok` coincident with acceptance -> write 32'h0000_80FF next cycle.
- LW in WAIT, `flush` pulsed, `data_ok` 2 cycles later -> no write; `wb_allowin`=0 until the cycle after `data_ok`, then 1.
- Back-to-back non-loads to waddr 0 and 31 -> `rf_we` high both cycles with waddr 0 then 31; with `WB_TRACE_EN`, `retire_cnt` increases by 2.
- `resetn` low mid-WAIT, then `data_ok` after release -> all outputs 0, no write, `wb_allowin`=1.
